button_event_ctrl: RTL and testbench

- Multi-button front-end controller: synchronises and debounces NUM_BTN raw switch inputs on a shared prescaled sample tick.
- Detects press, release and (optionally) long-press events per button.
- Arbitrates pending events round-robin onto a single valid/ready event stream.
- Sits between board push-buttons and any consumer FSM needing clean, one-shot button events.

---
 rtl/button_event_ctrl_if.sv | 13 +
 rtl/button_event_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_ctrl_if.sv
// Event stream bundle for button_event_ctrl: valid/ready handshake carrying a
// button index and a 2-bit event code. The master side is the controller.
interface button_event_ctrl_if #(
  parameter int ID_W = 2
);
  logic            EVT_VALID;
  logic            EVT_READY;
  logic [ID_W-1:0] EVT_ID;
  logic [1:0]      EVT_CODE;

  modport master (output EVT_VALID, output EVT_ID, output EVT_CODE, input EVT_READY);
  modport slave  (input EVT_VALID, input EVT_ID, input EVT_CODE, output EVT_READY);
endinterface

// File: rtl/button_event_ctrl.sv
// Multi-button front end: 2-flop sync, tick-based debounce, press/long/release
// events, round-robin arbitration onto one stream. Long press needs BUTTON_LONG_PRESS_EN.
module button_event_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_DIV     = 65536,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 64
) (
  input  logic                CLOCK,
  input  logic                NRESET,
  input  logic [NUM_BTN-1:0]  SWITCHI,
  output logic [NUM_BTN-1:0]  LEVEL,
  button_event_ctrl_if.master evt,
  output logic                OVERRUN
);

  localparam int ID_W  = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int STB_W = $clog2(STABLE_TICKS + 1);

  if (NUM_BTN < 1 || NUM_BTN > 16) begin : g_badNumBtn
    $error("button_event_ctrl: NUM_BTN must be 1..16");
  end
  if (TICK_DIV < 2) begin : g_badTickDiv
    $error("button_event_ctrl: TICK_DIV must be >= 2");
  end
  if (STABLE_TICKS < 1) begin : g_badStable
    $error("button_event_ctrl: STABLE_TICKS must be >= 1");
  end
  if (LONG_TICKS < 1) begin : g_badLong
    $error("button_event_ctrl: LONG_TICKS must be >= 1");
  end

  logic [PRE_W-1:0]   r_presc;
  logic               w_tick;
  logic [NUM_BTN-1:0] r_sync1, r_sync2, r_level;
  logic [NUM_BTN-1:0] w_rise, w_fall;
  logic [STB_W-1:0]   r_stabCnt  [NUM_BTN];
  logic [STB_W-1:0]   w_stabNext [NUM_BTN];

  logic [NUM_BTN-1:0] r_pendPress, r_pendRelease, w_pendLong, w_longSet;
  logic [NUM_BTN-1:0] w_grantPress, w_grantLong, w_grantRelease, w_anyPend;
  logic               r_evtValid, r_overrun, w_found, w_load, w_overrun;
  logic [ID_W-1:0]    r_evtId, r_rrPtr, w_winner, w_rrNext;
  logic [1:0]         r_evtCode, w_code;

  assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge CLOCK) begin
    if (!NRESET) begin
      r_presc <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_sync1 <= SWITCHI;
      r_sync2 <= r_sync1;
    end
  end

  // A level change is accepted on the tick that completes STABLE_TICKS differing samples.
  always_comb begin
    w_rise = '0;
    w_fall = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      w_stabNext[b] = r_stabCnt[b];
      if (w_tick) begin
        if (r_sync2[b] != r_level[b]) begin
          if (r_stabCnt[b] == STB_W'(STABLE_TICKS - 1)) begin
            w_stabNext[b] = '0;
            w_rise[b]     = ~r_level[b];
            w_fall[b]     = r_level[b];
          end else begin
            w_stabNext[b] = r_stabCnt[b] + 1'b1;
          end
        end else begin
          w_stabNext[b] = '0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!NRESET) begin
      r_level <= '0;
      for (int b = 0; b < NUM_BTN; b++) r_stabCnt[b] <= '0;
    end else begin
      r_level <= r_level ^ (w_rise | w_fall);
      for (int b = 0; b < NUM_BTN; b++) r_stabCnt[b] <= w_stabNext[b];
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int HLD_W = $clog2(LONG_TICKS + 1);

  logic [HLD_W-1:0]   r_holdCnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_pendLong;

  // Saturating hold counter makes the long event fire once per press.
  always_comb begin
    w_longSet = '0;
    for (int b = 0; b < NUM_BTN; b++)
      w_longSet[b] = w_tick && r_level[b] && (r_holdCnt[b] == HLD_W'(LONG_TICKS - 1));
  end

  always_ff @(posedge CLOCK) begin
    if (!NRESET) begin
      r_pendLong <= '0;
      for (int b = 0; b < NUM_BTN; b++) r_holdCnt[b] <= '0;
    end else begin
      r_pendLong <= (r_pendLong & ~w_grantLong) | w_longSet;
      for (int b = 0; b < NUM_BTN; b++) begin
        if (w_rise[b])
          r_holdCnt[b] <= '0;
        else if (w_tick && r_level[b] && (r_holdCnt[b] != HLD_W'(LONG_TICKS)))
          r_holdCnt[b] <= r_holdCnt[b] + 1'b1;
      end
    end
  end

  assign w_pendLong = r_pendLong;
`else
  assign w_longSet  = '0;
  assign w_pendLong = '0;
`endif

  // Round-robin: lowest pending index at or above the pointer, else lowest overall.
  always_comb begin
    w_load         = !r_evtValid || evt.EVT_READY;
    w_anyPend      = r_pendPress | r_pendRelease | w_pendLong;
    w_found        = 1'b0;
    w_winner       = '0;
    w_grantPress   = '0;
    w_grantLong    = '0;
    w_grantRelease = '0;
    w_code         = 2'b00;
    for (int b = NUM_BTN - 1; b >= 0; b--) begin
      if (w_anyPend[b] && (ID_W'(b) >= r_rrPtr)) begin
        w_found  = 1'b1;
        w_winner = ID_W'(b);
      end
    end
    if (!w_found) begin
      for (int b = NUM_BTN - 1; b >= 0; b--) begin
        if (w_anyPend[b]) begin
          w_found  = 1'b1;
          w_winner = ID_W'(b);
        end
      end
    end
    for (int b = 0; b < NUM_BTN; b++) begin
      if (w_load && w_found && (w_winner == ID_W'(b))) begin
        if (r_pendPress[b]) begin
          w_grantPress[b] = 1'b1;
          w_code          = 2'b01;
        end else if (w_pendLong[b]) begin
          w_grantLong[b] = 1'b1;
          w_code         = 2'b10;
        end else begin
          w_grantRelease[b] = 1'b1;
          w_code            = 2'b11;
        end
      end
    end
  end

  assign w_rrNext  = (w_winner == ID_W'(NUM_BTN - 1)) ? '0 : w_winner + 1'b1;
  assign w_overrun = |((w_rise    & r_pendPress   & ~w_grantPress)   |
                       (w_fall    & r_pendRelease & ~w_grantRelease) |
                       (w_longSet & w_pendLong    & ~w_grantLong));

  always_ff @(posedge CLOCK) begin
    if (!NRESET) begin
      r_pendPress   <= '0;
      r_pendRelease <= '0;
      r_evtValid    <= 1'b0;
      r_evtId       <= '0;
      r_evtCode     <= 2'b00;
      r_rrPtr       <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_pendPress   <= (r_pendPress & ~w_grantPress) | w_rise;
      r_pendRelease <= (r_pendRelease & ~w_grantRelease) | w_fall;
      r_overrun     <= w_overrun;
      if (w_load) begin
        r_evtValid <= w_found;
        if (w_found) begin
          r_evtId   <= w_winner;
          r_evtCode <= w_code;
          r_rrPtr   <= w_rrNext;
        end
      end
    end
  end

  assign LEVEL        = r_level;
  assign OVERRUN      = r_overrun;
  assign evt.EVT_VALID = r_evtValid;
  assign evt.EVT_ID    = r_evtId;
  assign evt.EVT_CODE  = r_evtCode;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: directed button scenarios push expected
// events; a negedge monitor pops and compares every accepted event.
module tb_button_event_ctrl;

  localparam int NUM_BTN      = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LONG_TICKS   = 8;

  typedef struct {
    int id;
    int code;
  } evt_t;

  logic               CLOCK = 1'b0;
  logic               NRESET = 1'b0;
  logic [NUM_BTN-1:0] SWITCHI = '0;
  logic [NUM_BTN-1:0] LEVEL;
  logic               OVERRUN;

  int   checks = 0;
  int   errors = 0;
  int   ovCount = 0;
  int   cyc = 0;
  bit   level0Seen = 1'b0;
  evt_t expQ[$];

  button_event_ctrl_if #(.ID_W(2)) bus();

  button_event_ctrl #(
    .NUM_BTN(NUM_BTN), .TICK_DIV(TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS), .LONG_TICKS(LONG_TICKS)
  ) dut (
    .CLOCK(CLOCK), .NRESET(NRESET), .SWITCHI(SWITCHI),
    .LEVEL(LEVEL), .evt(bus), .OVERRUN(OVERRUN)
  );

  always #5 CLOCK = ~CLOCK;

  // Cycle count since the last reset edge; equals the DUT prescaler phase modulo TICK_DIV.
  always @(posedge CLOCK) begin
    if (!NRESET) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Monitor: an event is accepted at the next rising edge when valid and ready are both high.
  always @(negedge CLOCK) begin
    evt_t e;
    if (OVERRUN) ovCount++;
    if (LEVEL[0]) level0Seen = 1'b1;
    if (NRESET && bus.EVT_VALID && bus.EVT_READY) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event got id=%0d code=%0d expected none",
                 bus.EVT_ID, bus.EVT_CODE);
      end else begin
        e = expQ.pop_front();
        if (int'(bus.EVT_ID) != e.id || int'(bus.EVT_CODE) != e.code) begin
          errors++;
          $display("[TB] FAIL event_match got id=%0d code=%0d expected id=%0d code=%0d",
                   bus.EVT_ID, bus.EVT_CODE, e.id, e.code);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick1();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int b, input logic v);
    SWITCHI[b] = v;
  endtask

  task automatic pushExp(input int id, input int code);
    evt_t e;
    e.id   = id;
    e.code = code;
    expQ.push_back(e);
  endtask

  task automatic waitLevel(input int b, input logic v, input int budget, input string name);
    int n = 0;
    while (LEVEL[b] !== v && n < budget) begin
      tick1();
      n++;
    end
    checkOutput(name, int'(LEVEL[b]), int'(v));
  endtask

  task automatic waitValid(input int budget, input string name);
    int n = 0;
    while (bus.EVT_VALID !== 1'b1 && n < budget) begin
      tick1();
      n++;
    end
    checkOutput(name, int'(bus.EVT_VALID), 1);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick1();
      n++;
    end
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
    waitCycles(4);
  endtask

  initial begin
    int ovStart;
    int j;

    bus.EVT_READY = 1'b1;
    waitCycles(2);
    NRESET = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_level", int'(LEVEL), 0);
    checkOutput("rst_valid", int'(bus.EVT_VALID), 0);
    checkOutput("rst_id", int'(bus.EVT_ID), 0);
    checkOutput("rst_code", int'(bus.EVT_CODE), 0);
    checkOutput("rst_overrun", int'(OVERRUN), 0);

    $display("[TB] round-robin with backpressure");
    bus.EVT_READY = 1'b0;
    applyStimulus(0, 1'b1);
    applyStimulus(3, 1'b1);
    waitLevel(0, 1'b1, 40, "rr_level0");
    checkOutput("rr_level3", int'(LEVEL[3]), 1);
    waitValid(4, "rr_valid");
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_hold_id", int'(bus.EVT_ID), 0);
      checkOutput("rr_hold_code", int'(bus.EVT_CODE), 1);
      tick1();
    end
    pushExp(0, 1);
    pushExp(3, 1);
    bus.EVT_READY = 1'b1;
    tick1();
    checkOutput("rr_next_valid", int'(bus.EVT_VALID), 1);
    checkOutput("rr_next_id", int'(bus.EVT_ID), 3);
    tick1();
    checkOutput("rr_idle_valid", int'(bus.EVT_VALID), 0);
    pushExp(0, 3);
    pushExp(3, 3);
    applyStimulus(0, 1'b0);
    applyStimulus(3, 1'b0);
    waitLevel(0, 1'b0, 40, "rr_release0");
    drain(20, "rr_drain");

    $display("[TB] clean press");
    while (cyc % TICK_DIV != 1) tick1();
    pushExp(2, 1);
    applyStimulus(2, 1'b1);
    waitCycles(10);
    checkOutput("clean_level_early", int'(LEVEL[2]), 0);
    tick1();
    checkOutput("clean_level_on_time", int'(LEVEL[2]), 1);
    tick1();
    checkOutput("clean_latency_valid", int'(bus.EVT_VALID), 1);
    checkOutput("clean_latency_id", int'(bus.EVT_ID), 2);
    pushExp(2, 3);
    applyStimulus(2, 1'b0);
    waitLevel(2, 1'b0, 40, "clean_release");
    drain(20, "clean_drain");

    $display("[TB] bounce");
    ovStart = ovCount;
    level0Seen = 1'b0;
    while (cyc % TICK_DIV != 2) tick1();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, (i % 2) == 0);
      waitCycles(2);
    end
    applyStimulus(0, 1'b0);
    waitCycles(30);
    checkOutput("bounce_level", int'(level0Seen), 0);
    checkOutput("bounce_overrun", ovCount - ovStart, 0);

    $display("[TB] long press then release");
    pushExp(1, 1);
`ifdef BUTTON_LONG_PRESS_EN
    pushExp(1, 2);
`endif
    applyStimulus(1, 1'b1);
    waitLevel(1, 1'b1, 40, "long_level_up");
    waitCycles(8 * TICK_DIV);
    pushExp(1, 3);
    applyStimulus(1, 1'b0);
    waitLevel(1, 1'b0, 40, "long_level_down");
    drain(40, "long_drain");

    $display("[TB] short press");
    pushExp(1, 1);
    applyStimulus(1, 1'b1);
    waitLevel(1, 1'b1, 40, "short_level_up");
    waitCycles(4 * TICK_DIV);
    pushExp(1, 3);
    applyStimulus(1, 1'b0);
    waitLevel(1, 1'b0, 40, "short_level_down");
    drain(40, "short_drain");

    $display("[TB] overrun under backpressure");
    bus.EVT_READY = 1'b0;
    pushExp(0, 1);
    applyStimulus(0, 1'b1);
    waitLevel(0, 1'b1, 40, "ovr_level0");
    waitValid(4, "ovr_valid");
    waitCycles(40);
    ovStart = ovCount;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2, 1'b1);
      waitLevel(2, 1'b1, 40, "ovr_level2_up");
      applyStimulus(2, 1'b0);
      waitLevel(2, 1'b0, 40, "ovr_level2_down");
    end
    waitCycles(3);
    checkOutput("ovr_count", ovCount - ovStart, 2);
    checkOutput("ovr_hold_id", int'(bus.EVT_ID), 0);
    checkOutput("ovr_hold_code", int'(bus.EVT_CODE), 1);
    pushExp(2, 1);
`ifdef BUTTON_LONG_PRESS_EN
    pushExp(0, 2);
`endif
    pushExp(2, 3);
    bus.EVT_READY = 1'b1;
    drain(40, "ovr_drain");
    pushExp(0, 3);
    applyStimulus(0, 1'b0);
    waitLevel(0, 1'b0, 40, "ovr_release0");
    drain(40, "ovr_release_drain");

    $display("[TB] reset mid-stream");
    bus.EVT_READY = 1'b0;
    applyStimulus(1, 1'b1);
    waitLevel(1, 1'b1, 40, "mid_level_up");
    waitValid(4, "mid_valid");
    NRESET  = 1'b0;
    SWITCHI = '0;
    tick1();
    NRESET = 1'b1;
    checkOutput("mid_rst_valid", int'(bus.EVT_VALID), 0);
    checkOutput("mid_rst_id", int'(bus.EVT_ID), 0);
    checkOutput("mid_rst_code", int'(bus.EVT_CODE), 0);
    checkOutput("mid_rst_level", int'(LEVEL), 0);
    checkOutput("mid_rst_overrun", int'(OVERRUN), 0);
    bus.EVT_READY = 1'b1;
    waitCycles(40);
    checkOutput("final_queue", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
